// File: rtl/seq_pattern_pkg.sv
// Shared constants for the sync-pattern frame transmitter: sync word,
// its width, one-hot FSM encodings and a small sizing helper.
package seq_pattern_pkg;

    localparam int                   PATTERN_W = 7;
    localparam logic [PATTERN_W-1:0] PATTERN   = 7'b1010011;

    typedef enum logic [3:0] {
        IDLE    = 4'b0001,
        SYNC    = 4'b0010,
        PAYLOAD = 4'b0100,
        GAP     = 4'b1000
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b; else m = m;
        if (c > m) m = c; else m = m;
        return m;
    endfunction

endpackage

// File: rtl/seq_pattern_tx_piso_shift.sv
// Parallel-in / serial-out shift register; the MSB is always presented on
// ser_o and moves out first.
module piso_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] par_i,
    output logic             ser_o
);

    logic [WIDTH-1:0] sr_q;

    // Load wins over shift; a shift pulls zeros in from the LSB end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (load_i) begin
            sr_q <= par_i;
        end else if (shift_i) begin
            sr_q <= sr_q << 1;
        end else begin
            sr_q <= sr_q;
        end
    end

    assign ser_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: 7-bit sync pattern then a payload word, both
// MSB first, with a fixed idle gap between frames.
module seq_pattern_tx
    import seq_pattern_pkg::*;
#(
    parameter int PAYLOAD_W  = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tx_valid,
    input  logic [PAYLOAD_W-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 data_out,
    output logic                 bit_valid,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int CNT_W = $clog2(max3(PATTERN_W, PAYLOAD_W, GAP_CYCLES) + 1);
    localparam int IDX_W = $clog2(PATTERN_W);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(PATTERN_W);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_W);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             data_out_q;
    logic             bit_valid_q;
    logic             frame_done_q;

    logic             load_s;
    logic             shift_s;
    logic             piso_bit_s;
    logic             pat_bit_s;

    // cnt_q counts bits already on the line, so it also indexes the next one
    always_comb begin
        load_s    = 1'b0;
        shift_s   = 1'b0;
        pat_bit_s = PATTERN[IDX_W'(PATTERN_W - 1) - IDX_W'(cnt_q)];
        if (state_q == IDLE) begin
            load_s = tx_valid;
        end else begin
            load_s = 1'b0;
        end
        if (((state_q == SYNC) && (cnt_q == SYNC_LAST)) ||
            ((state_q == PAYLOAD) && (cnt_q != PAY_LAST))) begin
            shift_s = 1'b1;
        end else begin
            shift_s = 1'b0;
        end
    end

    piso_shift #(.WIDTH(PAYLOAD_W)) u_piso (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load_s),
        .shift_i(shift_s),
        .par_i  (tx_data),
        .ser_o  (piso_bit_s)
    );

    // Frame sequencer: state, bit counter and the registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_out_q   <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    frame_done_q <= 1'b0;
                    if (tx_valid) begin
                        state_q     <= SYNC;
                        cnt_q       <= CNT_ONE;
                        data_out_q  <= PATTERN[PATTERN_W-1];
                        bit_valid_q <= 1'b1;
                    end else begin
                        cnt_q       <= '0;
                        data_out_q  <= 1'b0;
                        bit_valid_q <= 1'b0;
                    end
                end
                SYNC: begin
                    bit_valid_q <= 1'b1;
                    if (cnt_q == SYNC_LAST) begin
                        state_q      <= PAYLOAD;
                        cnt_q        <= CNT_ONE;
                        data_out_q   <= piso_bit_s;
                        frame_done_q <= (PAYLOAD_W == 1);
                    end else begin
                        cnt_q        <= cnt_q + CNT_ONE;
                        data_out_q   <= pat_bit_s;
                        frame_done_q <= 1'b0;
                    end
                end
                PAYLOAD: begin
                    if (cnt_q == PAY_LAST) begin
                        data_out_q   <= 1'b0;
                        bit_valid_q  <= 1'b0;
                        frame_done_q <= 1'b0;
                        if (GAP_CYCLES == 0) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            state_q <= GAP;
                            cnt_q   <= CNT_ONE;
                        end
                    end else begin
                        cnt_q        <= cnt_q + CNT_ONE;
                        data_out_q   <= piso_bit_s;
                        bit_valid_q  <= 1'b1;
                        frame_done_q <= (cnt_q == (PAY_LAST - CNT_ONE));
                    end
                end
                GAP: begin
                    data_out_q   <= 1'b0;
                    bit_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                    if (cnt_q == GAP_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q      <= IDLE;
                    cnt_q        <= '0;
                    data_out_q   <= 1'b0;
                    bit_valid_q  <= 1'b0;
                    frame_done_q <= 1'b0;
                end
            endcase
        end
    end

    assign data_out   = data_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign tx_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);

endmodule
